audio_sample_fifo: RTL and testbench
====================================

// Module: audio_sample_fifo
// PURPOSE
//  Stereo sample buffer directly upstream of i2s_transmitter. Host/sound logic pushes {left,right}
//  pairs via valid/ready. Each sample_pulse from the transmitter pops one pair onto DAC_Left/DAC_Right,
//  held stable for the whole 64-bit I2S frame. Flags low-water level (refill request) and underrun.
// PARAMETERS
//  BITS             16  audio sample width per channel, 8..24; must match the transmitter
//  DEPTH_LOG2       4   FIFO depth = 2**DEPTH_LOG2 stereo pairs, 2..10
//  LOW_WATER        4   refill_req asserted while level <= LOW_WATER; 0 .. 2**DEPTH_LOG2-1
//  HOLD_ON_UNDERRUN 1   1: DAC outputs hold the last pair on underrun; 0: DAC outputs go to 0
// PORTS
//  clk_in        in   1             system clock, same domain as i2s_transmitter
//  reset         in   1             synchronous, active-high reset
//  wr_valid      in   1             write request: pair on wr_left/wr_right is valid
//  wr_ready      out  1             FIFO can accept a pair this cycle
//  wr_left       in   BITS          left sample to push
//  wr_right      in   BITS          right sample to push
//  sample_pulse  in   1             1-cycle pop strobe from i2s_transmitter
//  DAC_Left      out  BITS          left sample to transmitter
//  DAC_Right     out  BITS          right sample to transmitter
//  level         out  DEPTH_LOG2+1  number of stored pairs, 0 .. 2**DEPTH_LOG2
//  empty         out  1             level == 0
//  refill_req    out  1             level <= LOW_WATER
//  underrun      out  1             1-cycle pulse: sample_pulse arrived while empty
// BEHAVIOUR
//  - Reset: rd_ptr = 0, wr_ptr = 0, level = 0; DAC_Left/DAC_Right = 0; underrun = 0.
//    Empty = 1 and refill_req = 1 are derived. Reset mid-operation discards all stored pairs.
//  - Storage: 2**DEPTH_LOG2 x (2*BITS) array; pointers are DEPTH_LOG2 bits and wrap modulo depth.
//    Level is a separate DEPTH_LOG2+1-bit register.
//  - wr_ready = (level != 2**DEPTH_LOG2), from the registered level only; no full-bypass.
//  - Push when wr_valid && wr_ready: mem[wr_ptr] <= {wr_left, wr_right}; wr_ptr++.
//  - Pop when sample_pulse && !empty:
//    - DAC_Left/DAC_Right <= mem[rd_ptr], visible the cycle after sample_pulse (latency 1 clk_in).
//    - Then rd_ptr++.
//  - Underrun when sample_pulse && empty:
//    - No pointer change; underrun = 1 for exactly the next cycle.
//    - DAC outputs hold (HOLD_ON_UNDERRUN = 1) or load 0 (HOLD_ON_UNDERRUN = 0).
//  - Level update:
//    - +1 on push only; -1 on pop only; unchanged on push and pop in the same cycle.
//  - Boundaries:
//    - Full + sample_pulse + wr_valid: pop occurs, push refused (wr_ready was 0); level -> depth-1.
//    - Empty + sample_pulse + push: underrun asserted; push is stored; level -> 1. No read-through bypass.
//    - Pointer wrap is transparent; data order is strict FIFO across the wrap.
//  - DAC outputs change only on a pop, an underrun with HOLD_ON_UNDERRUN = 0, or reset.
//  - Frame alignment: i2s_transmitter latches DAC_* at its counter==0 and emits sample_pulse at the same
//    point. A popped pair is therefore transmitted in the following frame: fixed 1-frame pipeline delay.
// CONFIGURATION
//  `AUDIO_FIFO_UNDERRUN_CNT_EN defined:
//   - Adds input underrun_clr (1) and output underrun_count (16).
//   - underrun_count increments on each underrun, saturates at 16'hFFFF.
//   - underrun_count is set to 0 by reset or underrun_clr. If underrun_clr and an underrun coincide,
//     the clear wins and the result is 0.
//  Not defined: both ports are absent; the underrun pulse is the only underrun indication.
// TESTING
//  1 Reset, then no writes: empty=1, refill_req=1, wr_ready=1, level=0, DAC_Left=DAC_Right=0.
//  2 Push L=16'h1111,R=16'h2222 and L=16'h3333,R=16'h4444, then two sample_pulses 64 pulses apart
//    -> DAC = 1111/2222, then 3333/4444, each 1 clk after its pulse; level 2 -> 1 -> 0.
//  3 Fill 16 pairs (DEPTH_LOG2=4): wr_ready=0 at level 16; wr_valid held high stores nothing.
//    One sample_pulse -> level 15, wr_ready=1; next write accepted. Pointer wrap keeps order.
//  4 sample_pulse while empty, last output 16'hABCD/16'h1234:
//    - HOLD=1: DAC stays ABCD/1234.
//    - HOLD=0: DAC becomes 0/0.
//    - Both: underrun high for exactly 1 cycle.
//  5 Level 5, push and sample_pulse in the same cycle -> level stays 5, popped pair correct, new pair last.
//    Level 0, same stimulus -> underrun pulse, level 1.
//  6 With AUDIO_FIFO_UNDERRUN_CNT_EN:
//    - 3 underruns -> underrun_count=3.
//    - underrun_clr coincident with a 4th underrun -> 0.
//    - Forced count 16'hFFFF + underrun -> stays 16'hFFFF.
//    - Reset mid-fill -> level 0, empty 1.

Source files
------------

// File: rtl/audio_sample_fifo.sv
// Stereo {left,right} sample FIFO feeding the I2S transmitter; one pair popped per sample_pulse.
// Optional build macro AUDIO_FIFO_UNDERRUN_CNT_EN adds underrun_clr / underrun_count.
module audio_sample_fifo #(
  parameter int BITS             = 16,
  parameter int DEPTH_LOG2       = 4,
  parameter int LOW_WATER        = 4,
  parameter int HOLD_ON_UNDERRUN = 1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [BITS-1:0]       wr_left,
  input  logic [BITS-1:0]       wr_right,
  input  logic                  sample_pulse,
  output logic [BITS-1:0]       DAC_Left,
  output logic [BITS-1:0]       DAC_Right,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  refill_req,
  output logic                  underrun
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
  ,
  input  logic                  underrun_clr,
  output logic [15:0]           underrun_count
`endif
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LOW_LVL   = LOW_WATER[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [2*BITS-1:0]     mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic [BITS-1:0]       dac_left_r;
  logic [BITS-1:0]       dac_right_r;
  logic                  underrun_r;
  logic                  push_s;
  logic                  pop_s;
  logic                  urun_s;
  logic                  empty_s;
  logic                  ready_s;
  logic [2*BITS-1:0]     rd_pair_s;

  // Status flags decode only the registered level, so wr_ready never depends on this cycle's pop.
  always_comb begin
    empty_s   = (level_r == {(DEPTH_LOG2+1){1'b0}});
    ready_s   = (level_r != DEPTH_LVL);
    rd_pair_s = mem_r[rd_ptr_r];
    push_s    = 1'b0;
    pop_s     = 1'b0;
    urun_s    = 1'b0;
    if (wr_valid && ready_s) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (sample_pulse && !empty_s) begin
      pop_s = 1'b1;
    end else if (sample_pulse) begin
      urun_s = 1'b1;
    end else begin
      pop_s  = 1'b0;
      urun_s = 1'b0;
    end
  end

  // Sample storage; contents need no reset because level gates every read.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {wr_left, wr_right};
    end
  end

  // Pointers, level, DAC holding registers and the underrun strobe.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr_r    <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r    <= {DEPTH_LOG2{1'b0}};
      level_r     <= {(DEPTH_LOG2+1){1'b0}};
      dac_left_r  <= {BITS{1'b0}};
      dac_right_r <= {BITS{1'b0}};
      underrun_r  <= 1'b0;
    end else begin
      underrun_r <= urun_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r    <= rd_ptr_r + PTR_ONE;
        dac_left_r  <= rd_pair_s[2*BITS-1:BITS];
        dac_right_r <= rd_pair_s[BITS-1:0];
      end else if (urun_s && (HOLD_ON_UNDERRUN == 0)) begin
        dac_left_r  <= {BITS{1'b0}};
        dac_right_r <= {BITS{1'b0}};
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt_r;

  // Saturating underrun counter; a clear beats a coincident underrun.
  always_ff @(posedge clk_in) begin
    if (reset || underrun_clr) begin
      urun_cnt_r <= 16'h0000;
    end else if (urun_s && (urun_cnt_r != 16'hFFFF)) begin
      urun_cnt_r <= urun_cnt_r + 16'h0001;
    end
  end

  assign underrun_count = urun_cnt_r;
`endif

  assign wr_ready   = ready_s;
  assign level      = level_r;
  assign empty      = empty_s;
  assign refill_req = (level_r <= LOW_LVL);
  assign underrun   = underrun_r;
  assign DAC_Left   = dac_left_r;
  assign DAC_Right  = dac_right_r;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: one hold-on-underrun instance and one zero-on-underrun instance.
`timescale 1ns/1ps
module tb_audio_sample_fifo;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [15:0] wr_left;
  logic [15:0] wr_right;
  logic        sample_pulse;
  logic        wr_ready, empty, refill_req, underrun;
  logic [15:0] dac_l, dac_r;
  logic [4:0]  level;
  logic        h0_wr_ready, h0_empty, h0_refill_req, h0_underrun;
  logic [15:0] h0_dac_l, h0_dac_r;
  logic [4:0]  h0_level;
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
  logic        underrun_clr;
  logic [15:0] underrun_count;
  logic [15:0] h0_underrun_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  audio_sample_fifo #(.BITS(16), .DEPTH_LOG2(4), .LOW_WATER(4), .HOLD_ON_UNDERRUN(1)) dut (
    .clk_in(clk_in), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_left(wr_left), .wr_right(wr_right), .sample_pulse(sample_pulse),
    .DAC_Left(dac_l), .DAC_Right(dac_r), .level(level), .empty(empty),
    .refill_req(refill_req), .underrun(underrun)
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    , .underrun_clr(underrun_clr), .underrun_count(underrun_count)
`endif
  );

  audio_sample_fifo #(.BITS(16), .DEPTH_LOG2(4), .LOW_WATER(4), .HOLD_ON_UNDERRUN(0)) dut_h0 (
    .clk_in(clk_in), .reset(reset), .wr_valid(wr_valid), .wr_ready(h0_wr_ready),
    .wr_left(wr_left), .wr_right(wr_right), .sample_pulse(sample_pulse),
    .DAC_Left(h0_dac_l), .DAC_Right(h0_dac_r), .level(h0_level), .empty(h0_empty),
    .refill_req(h0_refill_req), .underrun(h0_underrun)
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    , .underrun_clr(underrun_clr), .underrun_count(h0_underrun_count)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    wr_valid = 1'b1; wr_left = l; wr_right = r;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse();
    sample_pulse = 1'b1;
    tick();
    sample_pulse = 1'b0;
  endtask

  task automatic check_dac(input string tag, input logic [15:0] l, input logic [15:0] r);
    check_val({tag, "_L"}, {16'h0000, dac_l}, {16'h0000, l});
    check_val({tag, "_R"}, {16'h0000, dac_r}, {16'h0000, r});
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_left = 16'h0000; wr_right = 16'h0000; sample_pulse = 1'b0;
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    underrun_clr = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check_val("rst_empty", {31'd0, empty}, 32'd1);
    check_val("rst_refill", {31'd0, refill_req}, 32'd1);
    check_val("rst_ready", {31'd0, wr_ready}, 32'd1);
    check_val("rst_level", {27'd0, level}, 32'd0);
    check_val("rst_underrun", {31'd0, underrun}, 32'd0);
    check_dac("rst_dac", 16'h0000, 16'h0000);

    // Two pairs, popped 64 cycles apart
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    check_val("t2_level2", {27'd0, level}, 32'd2);
    check_val("t2_empty0", {31'd0, empty}, 32'd0);
    pulse();
    check_dac("t2_pop1", 16'h1111, 16'h2222);
    check_val("t2_level1", {27'd0, level}, 32'd1);
    for (int i = 0; i < 63; i++) tick();
    check_dac("t2_hold", 16'h1111, 16'h2222);
    pulse();
    check_dac("t2_pop2", 16'h3333, 16'h4444);
    check_val("t2_level0", {27'd0, level}, 32'd0);
    check_val("t2_empty1", {31'd0, empty}, 32'd1);

    // Fill to full across the pointer wrap
    for (int i = 0; i < 16; i++) push(16'h1000 + 16'(i), 16'h2000 + 16'(i));
    check_val("t3_level16", {27'd0, level}, 32'd16);
    check_val("t3_ready0", {31'd0, wr_ready}, 32'd0);
    check_val("t3_refill0", {31'd0, refill_req}, 32'd0);
    wr_valid = 1'b1; wr_left = 16'hDEAD; wr_right = 16'hBEEF;
    tick(); tick(); tick();
    check_val("t3_full_hold", {27'd0, level}, 32'd16);
    sample_pulse = 1'b1;
    tick();
    sample_pulse = 1'b0;
    check_val("t3_pop_level15", {27'd0, level}, 32'd15);
    check_val("t3_ready1", {31'd0, wr_ready}, 32'd1);
    check_dac("t3_pop0", 16'h1000, 16'h2000);
    tick();
    wr_valid = 1'b0;
    check_val("t3_refilled", {27'd0, level}, 32'd16);
    for (int k = 1; k <= 16; k++) begin
      pulse();
      if (k < 16) check_dac($sformatf("t3_order%0d", k), 16'h1000 + 16'(k), 16'h2000 + 16'(k));
      else        check_dac("t3_last", 16'hDEAD, 16'hBEEF);
      check_val($sformatf("t3_lvl%0d", k), {27'd0, level}, 32'(16 - k));
      check_val($sformatf("t3_rfq%0d", k), {31'd0, refill_req}, {31'd0, (16 - k) <= 4});
    end
    check_val("t3_h0_match", {16'h0000, h0_dac_l}, 32'h0000DEAD);

    // Underrun with last output ABCD/1234
    push(16'hABCD, 16'h1234);
    pulse();
    check_val("t4_h0_pre", {16'h0000, h0_dac_l}, 32'h0000ABCD);
    pulse();
    check_val("t4_urun1", {31'd0, underrun}, 32'd1);
    check_dac("t4_hold", 16'hABCD, 16'h1234);
    check_val("t4_h0_L", {16'h0000, h0_dac_l}, 32'd0);
    check_val("t4_h0_R", {16'h0000, h0_dac_r}, 32'd0);
    check_val("t4_level0", {27'd0, level}, 32'd0);
    tick();
    check_val("t4_urun_off", {31'd0, underrun}, 32'd0);

    // Simultaneous push and pop at level 5, then at level 0
    for (int i = 0; i < 5; i++) push(16'h5000 + 16'(i), 16'h6000 + 16'(i));
    wr_valid = 1'b1; wr_left = 16'h7777; wr_right = 16'h8888; sample_pulse = 1'b1;
    tick();
    wr_valid = 1'b0; sample_pulse = 1'b0;
    check_val("t5_level5", {27'd0, level}, 32'd5);
    check_val("t5_urun0", {31'd0, underrun}, 32'd0);
    check_dac("t5_pop", 16'h5000, 16'h6000);
    for (int k = 1; k <= 5; k++) begin
      pulse();
      if (k < 5) check_dac($sformatf("t5_order%0d", k), 16'h5000 + 16'(k), 16'h6000 + 16'(k));
      else       check_dac("t5_newlast", 16'h7777, 16'h8888);
    end
    wr_valid = 1'b1; wr_left = 16'h9999; wr_right = 16'hAAAA; sample_pulse = 1'b1;
    tick();
    wr_valid = 1'b0; sample_pulse = 1'b0;
    check_val("t5_e_urun", {31'd0, underrun}, 32'd1);
    check_val("t5_e_level1", {27'd0, level}, 32'd1);
    check_dac("t5_e_hold", 16'h7777, 16'h8888);
    check_val("t5_e_h0", {16'h0000, h0_dac_l}, 32'd0);
    pulse();
    check_dac("t5_e_pop", 16'h9999, 16'hAAAA);
    check_val("t5_e_level0", {27'd0, level}, 32'd0);

`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    // Underrun counter: count, clear-wins, saturation
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    check_val("t6_clr", {16'h0000, underrun_count}, 32'd0);
    pulse(); pulse(); pulse();
    check_val("t6_cnt3", {16'h0000, underrun_count}, 32'd3);
    underrun_clr = 1'b1; sample_pulse = 1'b1;
    tick();
    underrun_clr = 1'b0; sample_pulse = 1'b0;
    check_val("t6_clr_wins", {16'h0000, underrun_count}, 32'd0);
    sample_pulse = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    check_val("t6_cnt_max", {16'h0000, underrun_count}, 32'h0000FFFF);
    tick();
    sample_pulse = 1'b0;
    check_val("t6_saturate", {16'h0000, underrun_count}, 32'h0000FFFF);
`endif

    // Reset mid-fill discards stored pairs
    push(16'h0101, 16'h0202);
    push(16'h0303, 16'h0404);
    pulse();
    push(16'h0505, 16'h0606);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("rst_mid_level", {27'd0, level}, 32'd0);
    check_val("rst_mid_empty", {31'd0, empty}, 32'd1);
    check_dac("rst_mid_dac", 16'h0000, 16'h0000);
    pulse();
    check_val("rst_mid_urun", {31'd0, underrun}, 32'd1);
    check_dac("rst_mid_nodata", 16'h0000, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
